// File: rtl/nco_bank_tdm_if.sv
// Bus bundle for nco_bank_tdm: note inputs from the voice allocator,
// step/wave ROM ports and the mixed sample outputs.
interface nco_bank_tdm_if #(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 16
);
  logic [7*VOICES-1:0] NOTE_NUM;
  logic [7*VOICES-1:0] NOTE_VEL;
  logic [VOICES-1:0]   NOTE_ON;
  logic [6:0]          STEP_ADDR;
  logic [PHASE_W-1:0]  STEP_DATA;
  logic [6:0]          WAVE_PHASE;
  logic [7:0]          WAVE_DATA;
  logic [7:0]          SAMPLE_OUT;
  logic                SAMPLE_VALID;
  logic                OVERRUN;

  modport master (
    output NOTE_NUM, NOTE_VEL, NOTE_ON, STEP_DATA, WAVE_DATA,
    input  STEP_ADDR, WAVE_PHASE, SAMPLE_OUT, SAMPLE_VALID, OVERRUN
  );

  modport slave (
    input  NOTE_NUM, NOTE_VEL, NOTE_ON, STEP_DATA, WAVE_DATA,
    output STEP_ADDR, WAVE_PHASE, SAMPLE_OUT, SAMPLE_VALID, OVERRUN
  );
endinterface

// File: rtl/nco_bank_tdm.sv
// Time-multiplexed NCO bank: one shared phase/scale/mix datapath walks all
// voices once per sample tick and emits the averaged mix.
module nco_bank_tdm #(
  parameter int VOICES     = 4,
  parameter int PHASE_W    = 16,
  parameter int PRESCALE   = 3125,
  parameter int PRESCALE_W = 12
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  nco_bank_tdm_if.slave bus
);
  localparam int VW = $clog2(VOICES);
  localparam int MW = 8 + VW;

  typedef enum logic [2:0] {IDLE, FETCH, ACC, MIX, DONE} state_t;

  state_t              state, state_nx;
  logic [VW-1:0]       voice;
  logic [PHASE_W-1:0]  phase [VOICES];
  logic [VOICES-1:0]   restart;
  logic [VOICES-1:0]   note_q;
  logic [VOICES-1:0]   clr_mask;
  logic [PRESCALE_W-1:0] presc;
  logic [MW-1:0]       mix;
  logic [7:0]          sample_q;
  logic                overrun_q;
  logic                tick;
  logic                last_voice;
  logic                cur_on;
  logic [6:0]          cur_note;
  logic [6:0]          cur_vel;
  logic [PHASE_W-1:0]  next_phase;
  logic [14:0]         prod;
  logic [7:0]          scaled;
  logic [6:0]          step_addr;
  logic [6:0]          wave_phase;
  logic                sample_valid;

  always_comb begin
    tick       = CE && (presc == PRESCALE_W'(PRESCALE - 1));
    last_voice = (voice == VW'(VOICES - 1));
    cur_on     = bus.NOTE_ON[voice];
    cur_note   = bus.NOTE_NUM[7*voice +: 7];
    cur_vel    = bus.NOTE_VEL[7*voice +: 7];
    next_phase = (restart[voice] ? '0 : phase[voice]) + bus.STEP_DATA;
    prod       = 15'(bus.WAVE_DATA) * 15'(cur_vel);
    scaled     = cur_on ? 8'(prod >> 7) : '0;
    clr_mask   = (state == ACC) ? (VOICES'(1) << voice) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else if (CE) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = FETCH;
      FETCH:   state_nx = ACC;
      ACC:     state_nx = MIX;
      MIX:     state_nx = last_voice ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ROM addresses are only meaningful in their slots; zero elsewhere.
  always_comb begin
    step_addr    = '0;
    wave_phase   = '0;
    sample_valid = 1'b0;
    case (state)
      FETCH:   step_addr = cur_note;
      ACC:     wave_phase = next_phase[PHASE_W-1 -: 7];
      DONE:    sample_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc     <= '0;
      note_q    <= '0;
      restart   <= '0;
      voice     <= '0;
      mix       <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) phase[i] <= '0;
    end else if (CE) begin
      presc  <= tick ? '0 : presc + 1'b1;
      note_q <= bus.NOTE_ON;
      // A rise landing on the voice's own ACC slot survives to the next frame.
      restart <= (restart & ~clr_mask) | (bus.NOTE_ON & ~note_q);
      if (tick && state != IDLE) overrun_q <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          voice <= '0;
          mix   <= '0;
        end
        ACC: if (cur_on) phase[voice] <= next_phase;
        MIX: begin
          mix <= mix + MW'(scaled);
          if (!last_voice) voice <= voice + 1'b1;
        end
        DONE: sample_q <= mix[MW-1 -: 8];
        default: ;
      endcase
    end
  end

  assign bus.STEP_ADDR    = step_addr;
  assign bus.WAVE_PHASE   = wave_phase;
  assign bus.SAMPLE_OUT   = sample_q;
  assign bus.SAMPLE_VALID = sample_valid;
  assign bus.OVERRUN      = overrun_q;
endmodule

// File: tb/tb_nco_bank_tdm.sv
// Self-checking bench for nco_bank_tdm: frame-level reference model with
// behavioural step/wave ROMs, plus a second instance for overrun behaviour.
module tb_nco_bank_tdm;
  localparam int P   = 30;
  localparam int LAT = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic ce_ovr = 1'b1;
  int   cnt, wc;
  int   errors = 0;
  int   checks = 0;
  int   step_mode = 1;
  int   wave_mode = 0;

  logic [6:0]  nn [4];
  logic [6:0]  vl [4];
  logic [3:0]  on_v;
  logic [3:0]  m_prev;
  logic [3:0]  m_restart;
  logic [15:0] m_phase [4];
  logic [6:0]  wp_log [256];

  nco_bank_tdm_if #(.VOICES(4), .PHASE_W(16)) bus ();
  nco_bank_tdm_if #(.VOICES(4), .PHASE_W(16)) bus2 ();

  nco_bank_tdm #(.VOICES(4), .PHASE_W(16), .PRESCALE(P), .PRESCALE_W(12)) dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .bus(bus)
  );
  nco_bank_tdm #(.VOICES(4), .PHASE_W(16), .PRESCALE(10), .PRESCALE_W(4)) dut_ovr (
    .CLK(clk), .RST_N(rst_n), .CE(ce_ovr), .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step_fn(input logic [6:0] a);
    if (step_mode == 0) return 16'h4000;
    return 16'(int'(a) * 613 + 97);
  endfunction

  function automatic logic [7:0] wave_fn(input logic [6:0] wp);
    case (wave_mode)
      0:       return 8'hFF;
      1:       return {wp, 1'b0};
      default: return 8'(int'(wp) * 37) ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.STEP_DATA  <= step_fn(bus.STEP_ADDR);
    bus.WAVE_DATA  <= wave_fn(bus.WAVE_PHASE);
    bus2.STEP_DATA <= 16'h1234;
    bus2.WAVE_DATA <= 8'hFF;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      wc  <= 0;
    end else begin
      wc <= wc + 1;
      if (ce) cnt <= cnt + 1;
    end
  end

  always @(negedge clk) wp_log[cnt[7:0]] = bus.WAVE_PHASE;

  task automatic apply_notes();
    for (int i = 0; i < 4; i++) begin
      bus.NOTE_NUM[7*i +: 7] = nn[i];
      bus.NOTE_VEL[7*i +: 7] = vl[i];
      if (on_v[i] && !m_prev[i]) m_restart[i] = 1'b1;
    end
    bus.NOTE_ON = on_v;
    m_prev = on_v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    m_restart = '0;
    m_prev = '0;
    apply_notes();
  endtask

  // One sample frame as the spec describes it: per-voice phase step, wave lookup,
  // velocity scaling, then the average of the four contributions.
  task automatic model_frame(output logic [7:0] e);
    int sum;
    logic [15:0] np;
    sum = 0;
    for (int v = 0; v < 4; v++) begin
      np = (m_restart[v] ? 16'h0 : m_phase[v]) + step_fn(nn[v]);
      if (on_v[v]) begin
        m_phase[v] = np;
        sum += (int'(wave_fn(np[15:9])) * int'(vl[v])) / 128;
      end
      m_restart[v] = 1'b0;
    end
    e = 8'(sum / 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int idx, output int wall,
                            output logic [7:0] val, output logic still);
    ok = 1'b0; idx = -1; wall = -1; val = '0; still = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.SAMPLE_VALID) begin
        ok = 1'b1; idx = cnt; wall = wc;
        break;
      end
    end
    if (ok) begin
      @(negedge clk);
      val = bus.SAMPLE_OUT;
      still = bus.SAMPLE_VALID;
    end
  endtask

  task automatic set_all(input logic [3:0] on, input logic [6:0] vel);
    for (int i = 0; i < 4; i++) begin
      nn[i] = 7'(10 + 17*i);
      vl[i] = vel;
    end
    on_v = on;
  endtask

  task automatic test_reset();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    set_all(4'h0, 7'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.SAMPLE_OUT !== 8'h00) begin errors++; $display("FAIL reset_out got %0h want 00", bus.SAMPLE_OUT); end
    checks++; if (bus.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.SAMPLE_VALID); end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", bus.OVERRUN); end
    checks++; if (bus2.OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun2 got %0b want 0", bus2.OVERRUN); end
    rst_n = 1'b1;
    model_reset();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || idx !== P + LAT - 1) begin errors++; $display("FAIL reset_first_frame got idx %0d want %0d", idx, P + LAT - 1); end
    checks++; if (val !== e) begin errors++; $display("FAIL reset_silent_frame got %0h want %0h", val, e); end
  endtask

  task automatic test_single_voice();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    step_mode = 1; wave_mode = 0;
    set_all(4'b0001, 7'd127);
    do_reset();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || idx !== P - 1 + LAT) begin errors++; $display("FAIL single_latency got idx %0d want %0d", idx, P - 1 + LAT); end
    checks++; if (val !== 8'h3F) begin errors++; $display("FAIL single_level got %0h want 3f", val); end
    checks++; if (val !== e) begin errors++; $display("FAIL single_model got %0h want %0h", val, e); end
    checks++; if (still !== 1'b0) begin errors++; $display("FAIL single_strobe_width got %0b want 0", still); end
  endtask

  task automatic test_all_voices();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    set_all(4'b1111, 7'd127);
    apply_notes();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || idx !== 2*P + LAT - 1) begin errors++; $display("FAIL all_period got idx %0d want %0d", idx, 2*P + LAT - 1); end
    checks++; if (val !== 8'hFD) begin errors++; $display("FAIL all_full got %0h want fd", val); end
    set_all(4'b1111, 7'd64);
    apply_notes();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (val !== 8'd127 || !ok) begin errors++; $display("FAIL all_half got %0h want 7f", val); end
    checks++; if (val !== e) begin errors++; $display("FAIL all_half_model got %0h want %0h", val, e); end
  endtask

  task automatic test_phase_wrap();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    logic [6:0] want_wp; logic [15:0] want_ph;
    step_mode = 0; wave_mode = 1;
    set_all(4'b0001, 7'd127);
    do_reset();
    for (int f = 0; f < 5; f++) begin
      want_wp = 7'(32 * (f + 1));
      want_ph = 16'(32'h4000 * (f + 1));
      wait_valid(3*P, ok, idx, wall, val, still);
      model_frame(e);
      checks++; if (!ok || wp_log[8'(idx - 11)] !== want_wp) begin errors++; $display("FAIL wrap_wave_phase[%0d] got %0h want %0h", f, wp_log[8'(idx - 11)], want_wp); end
      checks++; if (dut.phase[0] !== want_ph) begin errors++; $display("FAIL wrap_phase_reg[%0d] got %0h want %0h", f, dut.phase[0], want_ph); end
      checks++; if (val !== e) begin errors++; $display("FAIL wrap_sample[%0d] got %0h want %0h", f, val, e); end
    end
  endtask

  task automatic test_restart();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    step_mode = 0; wave_mode = 1;
    set_all(4'b0010, 7'd127);
    do_reset();
    for (int f = 0; f < 3; f++) begin
      wait_valid(3*P, ok, idx, wall, val, still);
      model_frame(e);
    end
    checks++; if (dut.phase[1] !== 16'hC000) begin errors++; $display("FAIL restart_pre_phase got %0h want c000", dut.phase[1]); end
    on_v = 4'b0000;
    apply_notes();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || val !== 8'h00) begin errors++; $display("FAIL gated_off_sample got %0h want 00", val); end
    checks++; if (dut.phase[1] !== 16'hC000) begin errors++; $display("FAIL gated_off_frozen got %0h want c000", dut.phase[1]); end
    on_v = 4'b0010;
    apply_notes();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || wp_log[8'(idx - 8)] !== 7'h20) begin errors++; $display("FAIL restart_wave_phase got %0h want 20", wp_log[8'(idx - 8)]); end
    checks++; if (val !== e) begin errors++; $display("FAIL restart_sample got %0h want %0h", val, e); end
  endtask

  task automatic test_random();
    bit ok; int idx, wall, want_idx; logic [7:0] val, e; logic still;
    step_mode = 1; wave_mode = 2;
    set_all(4'b0000, 7'd0);
    do_reset();
    want_idx = P + LAT - 1;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 4; i++) begin
        nn[i] = 7'($urandom_range(127, 0));
        vl[i] = 7'($urandom_range(127, 0));
      end
      on_v = 4'($urandom_range(15, 0));
      apply_notes();
      wait_valid(3*P, ok, idx, wall, val, still);
      model_frame(e);
      checks++; if (!ok || idx !== want_idx) begin errors++; $display("FAIL rand_timing[%0d] got %0d want %0d", f, idx, want_idx); end
      checks++; if (val !== e) begin errors++; $display("FAIL rand_sample[%0d] got %0h want %0h", f, val, e); end
      want_idx += P;
    end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL no_overrun got %0b want 0", bus.OVERRUN); end
  endtask

  task automatic test_ce_freeze();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    step_mode = 1; wave_mode = 2;
    set_all(4'b1111, 7'd100);
    do_reset();
    for (int i = 0; i < 3*P && cnt != P + 3; i++) @(negedge clk);
    ce = 1'b0;
    repeat (50) @(negedge clk);
    ce = 1'b1;
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || idx !== P + LAT - 1) begin errors++; $display("FAIL freeze_ce_cycles got %0d want %0d", idx, P + LAT - 1); end
    checks++; if (wall !== P + LAT - 1 + 50) begin errors++; $display("FAIL freeze_shift got %0d want %0d", wall, P + LAT - 1 + 50); end
    checks++; if (val !== e) begin errors++; $display("FAIL freeze_sample got %0h want %0h", val, e); end
  endtask

  task automatic test_overrun();
    logic pv; int frames;
    logic want_ovr, want_v;
    do_reset();
    pv = 1'b0; frames = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      want_ovr = (wc >= 20);
      want_v = (wc >= 22) && ((wc - 2) % 20 == 0);
      checks++; if (bus2.OVERRUN !== want_ovr) begin errors++; $display("FAIL overrun_flag@%0d got %0b want %0b", wc, bus2.OVERRUN, want_ovr); end
      checks++; if (bus2.SAMPLE_VALID !== want_v) begin errors++; $display("FAIL overrun_valid@%0d got %0b want %0b", wc, bus2.SAMPLE_VALID, want_v); end
      if (pv) begin
        checks++; if (bus2.SAMPLE_OUT !== 8'hFD) begin errors++; $display("FAIL overrun_sample@%0d got %0h want fd", wc, bus2.SAMPLE_OUT); end
      end
      if (bus2.SAMPLE_VALID) frames++;
      pv = bus2.SAMPLE_VALID;
    end
    checks++; if (frames !== 4) begin errors++; $display("FAIL overrun_frames got %0d want 4", frames); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int idx, wall; logic [7:0] val, e; logic still;
    step_mode = 1; wave_mode = 0;
    set_all(4'b1111, 7'd0);
    for (int i = 0; i < 4; i++) vl[i] = 7'($urandom_range(127, 64));
    do_reset();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || val !== e) begin errors++; $display("FAIL midreset_pre got %0h want %0h", val, e); end
    for (int i = 0; i < 3*P && cnt != 2*P + 8; i++) @(negedge clk);
    checks++; if (cnt !== 2*P + 8) begin errors++; $display("FAIL midreset_reach got %0d want %0d", cnt, 2*P + 8); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.SAMPLE_OUT !== 8'h00) begin errors++; $display("FAIL midreset_out got %0h want 00", bus.SAMPLE_OUT); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (bus.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL midreset_valid[%0d] got %0b want 0", i, bus.SAMPLE_VALID); end
    end
    rst_n = 1'b1;
    model_reset();
    wait_valid(3*P, ok, idx, wall, val, still);
    model_frame(e);
    checks++; if (!ok || idx !== P + LAT - 1) begin errors++; $display("FAIL midreset_next_idx got %0d want %0d", idx, P + LAT - 1); end
    checks++; if (val !== e) begin errors++; $display("FAIL midreset_next_sample got %0h want %0h", val, e); end
  endtask

  initial begin
    bus.NOTE_NUM  = '0;
    bus.NOTE_VEL  = '0;
    bus.NOTE_ON   = '0;
    bus2.NOTE_NUM = '0;
    bus2.NOTE_VEL = {4{7'd127}};
    bus2.NOTE_ON  = 4'hF;
    m_prev = '0;
    m_restart = '0;
    on_v = '0;
    test_reset();
    test_single_voice();
    test_all_voices();
    test_phase_wrap();
    test_restart();
    test_random();
    test_ce_freeze();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
